// File: rtl/free_list_pkg.sv
// Shared widths, types and helpers for the physical-register free list.
// Bitmaps are indexed by preg number; a set bit means the preg is free.
package free_list_pkg;

  localparam int NUM_PREGS  = 64;
  localparam int PREG_IDX_W = 6;
  localparam int NUM_ARCH   = 32;
  localparam int CNT_W      = 7;

  typedef logic [PREG_IDX_W-1:0] preg_idx_t;
  typedef logic [NUM_PREGS-1:0]  preg_mask_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  localparam preg_mask_t ONE_MASK        = {{(NUM_PREGS-1){1'b0}}, 1'b1};
  localparam preg_mask_t RESET_FREE_MASK = {{(NUM_PREGS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
  localparam cnt_t       RESET_FREE_CNT  = cnt_t'(NUM_PREGS - NUM_ARCH);

  // 6-to-64 one-hot decode of a preg index.
  function automatic preg_mask_t decode_preg(input preg_idx_t idx);
    decode_preg = ONE_MASK << idx;
  endfunction

  function automatic preg_idx_t lowest_set(input preg_mask_t v);
    preg_idx_t r;
    r = '0;
    for (int i = NUM_PREGS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = preg_idx_t'(i);
      end else begin
        r = r;
      end
    end
    lowest_set = r;
  endfunction

  function automatic cnt_t lane_sum(input logic [2:0] b);
    lane_sum = cnt_t'(b[0]) + cnt_t'(b[1]) + cnt_t'(b[2]);
  endfunction

endpackage

// File: rtl/triple_priority_encoder_ver3.sv
// Picks the three lowest set bits of a 64-bit vector, lowest first.
// Each lane reports its index and one-hot bit only when its enable is high.
module triple_priority_encoder_ver3
  import free_list_pkg::*;
(
  input  logic [NUM_PREGS-1:0]  vec_i,
  input  logic [2:0]            en_i,
  output logic [PREG_IDX_W-1:0] idx0_o,
  output logic [PREG_IDX_W-1:0] idx1_o,
  output logic [PREG_IDX_W-1:0] idx2_o,
  output logic [NUM_PREGS-1:0]  grant_mask_o
);

  preg_mask_t oh0, oh1, oh2;
  preg_mask_t rem1, rem2;

  // Peel off the lowest set bit three times; v & -v isolates it.
  always_comb begin
    oh0  = vec_i & (~vec_i + ONE_MASK);
    rem1 = vec_i & ~oh0;
    oh1  = rem1 & (~rem1 + ONE_MASK);
    rem2 = rem1 & ~oh1;
    oh2  = rem2 & (~rem2 + ONE_MASK);

    if (en_i[0]) begin
      idx0_o = lowest_set(vec_i);
    end else begin
      idx0_o = '0;
    end
    if (en_i[1]) begin
      idx1_o = lowest_set(rem1);
    end else begin
      idx1_o = '0;
    end
    if (en_i[2]) begin
      idx2_o = lowest_set(rem2);
    end else begin
      idx2_o = '0;
    end

    grant_mask_o = (en_i[0] ? oh0 : '0) | (en_i[1] ? oh1 : '0) | (en_i[2] ? oh2 : '0);
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Speculative/committed physical-register free list for a 3-wide rename stage.
// Grants are combinational from registered state; commits and flush update on clk.
module phys_reg_free_list
  import free_list_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            alloc_num,
  output logic                  alloc_ok,
  output logic [PREG_IDX_W-1:0] alloc_idx0,
  output logic [PREG_IDX_W-1:0] alloc_idx1,
  output logic [PREG_IDX_W-1:0] alloc_idx2,
  input  logic [2:0]            commit_en,
  input  logic [PREG_IDX_W-1:0] commit_new_preg0,
  input  logic [PREG_IDX_W-1:0] commit_new_preg1,
  input  logic [PREG_IDX_W-1:0] commit_new_preg2,
  input  logic [PREG_IDX_W-1:0] commit_old_preg0,
  input  logic [PREG_IDX_W-1:0] commit_old_preg1,
  input  logic [PREG_IDX_W-1:0] commit_old_preg2,
  input  logic                  flush,
  output logic [CNT_W-1:0]      free_count,
  output logic                  err_double_free
);

  preg_mask_t spec_free_q, spec_free_d;
  preg_mask_t comm_free_q, comm_free_d;
  cnt_t       spec_cnt_q,  spec_cnt_d;
  cnt_t       comm_cnt_q,  comm_cnt_d;
  logic       err_q,       err_d;

  logic                      alloc_ok_s;
  logic                      fire_s;
  logic [2:0]                lane_en_s;
  preg_mask_t                grant_mask_s;
  cnt_t                      alloc_cnt_s;

  logic [2:0][PREG_IDX_W-1:0] old_idx_s;
  logic [2:0][PREG_IDX_W-1:0] new_idx_s;
  logic [2:0]                 has_old_s;
  logic [2:0]                 already_free_s;
  logic [2:0]                 dup_old_s;
  logic [2:0]                 dup_new_s;
  logic [2:0]                 free_eff_s;
  logic [2:0]                 new_eff_s;
  logic [2:0]                 dbl_s;
  preg_mask_t                 free_mask_s;
  preg_mask_t                 new_mask_s;
  preg_mask_t                 comm_set_s;
  cnt_t                       n_free_s;
  cnt_t                       n_new_s;

  assign old_idx_s = {commit_old_preg2, commit_old_preg1, commit_old_preg0};
  assign new_idx_s = {commit_new_preg2, commit_new_preg1, commit_new_preg0};

  // Grant qualification: all-or-nothing, suppressed during flush.
  always_comb begin
    alloc_ok_s   = !flush && (spec_cnt_q >= cnt_t'(alloc_num));
    lane_en_s[0] = alloc_ok_s && (alloc_num != 2'd0);
    lane_en_s[1] = alloc_ok_s && (alloc_num >= 2'd2);
    lane_en_s[2] = alloc_ok_s && (alloc_num == 2'd3);
    fire_s       = alloc_ok_s && (alloc_num != 2'd0);
    if (fire_s) begin
      alloc_cnt_s = cnt_t'(alloc_num);
    end else begin
      alloc_cnt_s = '0;
    end
  end

  triple_priority_encoder_ver3 u_pick (
    .vec_i        (spec_free_q),
    .en_i         (lane_en_s),
    .idx0_o       (alloc_idx0),
    .idx1_o       (alloc_idx1),
    .idx2_o       (alloc_idx2),
    .grant_mask_o (grant_mask_s)
  );

  // Commit lanes: a free counts only if it actually flips a bit, so counts track bitmaps.
  always_comb begin
    dup_old_s[0] = 1'b0;
    dup_old_s[1] = commit_en[0] && (old_idx_s[0] == old_idx_s[1]);
    dup_old_s[2] = (commit_en[0] && (old_idx_s[0] == old_idx_s[2])) ||
                   (commit_en[1] && (old_idx_s[1] == old_idx_s[2]));
    dup_new_s[0] = 1'b0;
    dup_new_s[1] = commit_en[0] && (new_idx_s[0] == new_idx_s[1]);
    dup_new_s[2] = (commit_en[0] && (new_idx_s[0] == new_idx_s[2])) ||
                   (commit_en[1] && (new_idx_s[1] == new_idx_s[2]));

    free_mask_s = '0;
    for (int i = 0; i < 3; i++) begin
      has_old_s[i]      = commit_en[i] && (old_idx_s[i] != '0);
      already_free_s[i] = comm_free_q[old_idx_s[i]];
      dbl_s[i]          = has_old_s[i] && (already_free_s[i] || dup_old_s[i]);
      free_eff_s[i]     = has_old_s[i] && !already_free_s[i] && !dup_old_s[i];
      if (free_eff_s[i]) begin
        free_mask_s = free_mask_s | decode_preg(old_idx_s[i]);
      end else begin
        free_mask_s = free_mask_s;
      end
    end

    comm_set_s = comm_free_q | free_mask_s;
    new_mask_s = '0;
    for (int j = 0; j < 3; j++) begin
      new_eff_s[j] = commit_en[j] && comm_set_s[new_idx_s[j]] && !dup_new_s[j];
      if (new_eff_s[j]) begin
        new_mask_s = new_mask_s | decode_preg(new_idx_s[j]);
      end else begin
        new_mask_s = new_mask_s;
      end
    end

    n_free_s = lane_sum(free_eff_s);
    n_new_s  = lane_sum(new_eff_s);
  end

  // Next-state: committed list absorbs commits; speculative list is rebuilt from it on flush.
  always_comb begin
    comm_free_d = comm_set_s & ~new_mask_s;
    comm_cnt_d  = comm_cnt_q + n_free_s - n_new_s;
    if (flush) begin
      spec_free_d = comm_free_d;
      spec_cnt_d  = comm_cnt_d;
    end else begin
      spec_free_d = (spec_free_q & ~grant_mask_s) | free_mask_s;
      spec_cnt_d  = spec_cnt_q - alloc_cnt_s + n_free_s;
    end
    err_d = err_q | (|dbl_s);
  end

  // State registers with asynchronous reset to the identity-mapped architectural state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spec_free_q <= RESET_FREE_MASK;
      comm_free_q <= RESET_FREE_MASK;
      spec_cnt_q  <= RESET_FREE_CNT;
      comm_cnt_q  <= RESET_FREE_CNT;
      err_q       <= 1'b0;
    end else begin
      spec_free_q <= spec_free_d;
      comm_free_q <= comm_free_d;
      spec_cnt_q  <= spec_cnt_d;
      comm_cnt_q  <= comm_cnt_d;
      err_q       <= err_d;
    end
  end

  assign alloc_ok        = alloc_ok_s;
  assign free_count      = spec_cnt_q;
  assign err_double_free = err_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed, table-driven bench for phys_reg_free_list with a hand-written
// asynchronous-reset sequence at the end.
module tb_phys_reg_free_list;

  logic       clk;
  logic       reset;
  logic [1:0] alloc_num;
  logic       alloc_ok;
  logic [5:0] alloc_idx0, alloc_idx1, alloc_idx2;
  logic [2:0] commit_en;
  logic [5:0] commit_new_preg0, commit_new_preg1, commit_new_preg2;
  logic [5:0] commit_old_preg0, commit_old_preg1, commit_old_preg2;
  logic       flush;
  logic [6:0] free_count;
  logic       err_double_free;

  int n_total;
  int n_pass;

  phys_reg_free_list dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_num        (alloc_num),
    .alloc_ok         (alloc_ok),
    .alloc_idx0       (alloc_idx0),
    .alloc_idx1       (alloc_idx1),
    .alloc_idx2       (alloc_idx2),
    .commit_en        (commit_en),
    .commit_new_preg0 (commit_new_preg0),
    .commit_new_preg1 (commit_new_preg1),
    .commit_new_preg2 (commit_new_preg2),
    .commit_old_preg0 (commit_old_preg0),
    .commit_old_preg1 (commit_old_preg1),
    .commit_old_preg2 (commit_old_preg2),
    .flush            (flush),
    .free_count       (free_count),
    .err_double_free  (err_double_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] num;
    logic [2:0] cen;
    logic [5:0] n0, o0, n1, o1, n2, o2;
    logic       fl;
    logic       eok;
    logic [5:0] e0, e1, e2;
    logic [6:0] ecnt;
    logic       eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rst, int num, int cen, int n0, int o0, int n1, int o1,
                              int n2, int o2, int fl, int eok, int e0, int e1, int e2,
                              int ecnt, int eerr);
    vec_t v;
    v.rst = rst[0];  v.num = num[1:0]; v.cen = cen[2:0];
    v.n0 = n0[5:0];  v.o0 = o0[5:0];   v.n1 = n1[5:0]; v.o1 = o1[5:0];
    v.n2 = n2[5:0];  v.o2 = o2[5:0];   v.fl = fl[0];   v.eok = eok[0];
    v.e0 = e0[5:0];  v.e1 = e1[5:0];   v.e2 = e2[5:0];
    v.ecnt = ecnt[6:0]; v.eerr = eerr[0];
    return v;
  endfunction

  // Plain allocation vector: no commit, no flush.
  function automatic vec_t mka(int rst, int num, int eok, int e0, int e1, int e2,
                               int ecnt, int eerr);
    return mk(rst, num, 0, 0, 0, 0, 0, 0, 0, 0, eok, e0, e1, e2, ecnt, eerr);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    alloc_num = 2'd0; commit_en = 3'd0; flush = 1'b0;
    commit_new_preg0 = 6'd0; commit_new_preg1 = 6'd0; commit_new_preg2 = 6'd0;
    commit_old_preg0 = 6'd0; commit_old_preg1 = 6'd0; commit_old_preg2 = 6'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    drive_idle();

    // Burst drain from reset: ten full grants, then 3-with-2-free, then the last pair, then empty.
    for (int k = 0; k < 10; k++) begin
      tbl.push_back(mka((k == 0) ? 1 : 0, 3, 1, 32 + 3*k, 33 + 3*k, 34 + 3*k, 32 - 3*k, 0));
    end
    tbl.push_back(mka(0, 3, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mka(0, 2, 1, 62, 63, 0, 2, 0));
    tbl.push_back(mka(0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mka(0, 1, 0, 0, 0, 0, 0, 0));
    // Commit returns preg 5, grantable next cycle.
    tbl.push_back(mka(1, 3, 1, 32, 33, 34, 32, 0));
    tbl.push_back(mk(0, 0, 1, 32, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 29, 0));
    tbl.push_back(mka(0, 1, 1, 5, 0, 0, 30, 0));
    tbl.push_back(mka(0, 0, 1, 0, 0, 0, 29, 0));
    // Commit then flush (with a suppressed alloc): speculative list rebuilt from committed.
    tbl.push_back(mka(1, 3, 1, 32, 33, 34, 32, 0));
    tbl.push_back(mka(0, 3, 1, 35, 36, 37, 29, 0));
    tbl.push_back(mk(0, 0, 1, 32, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 26, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 27, 0));
    tbl.push_back(mka(0, 3, 1, 3, 33, 34, 32, 0));
    tbl.push_back(mka(0, 0, 1, 0, 0, 0, 29, 0));
    // Preg 0 never freed; double free of an already-free preg and of a lane duplicate.
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32, 0));
    tbl.push_back(mk(0, 0, 1, 0, 40, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32, 0));
    tbl.push_back(mka(0, 1, 1, 32, 0, 0, 32, 1));
    tbl.push_back(mk(0, 0, 3, 0, 10, 0, 10, 0, 0, 0, 1, 0, 0, 0, 31, 1));
    tbl.push_back(mka(0, 0, 1, 0, 0, 0, 32, 1));
    tbl.push_back(mka(0, 3, 1, 10, 33, 34, 32, 1));
    tbl.push_back(mka(0, 0, 1, 0, 0, 0, 29, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (tbl[i].rst) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
      alloc_num = tbl[i].num;  commit_en = tbl[i].cen;  flush = tbl[i].fl;
      commit_new_preg0 = tbl[i].n0; commit_old_preg0 = tbl[i].o0;
      commit_new_preg1 = tbl[i].n1; commit_old_preg1 = tbl[i].o1;
      commit_new_preg2 = tbl[i].n2; commit_old_preg2 = tbl[i].o2;
      #1;
      check($sformatf("v%0d_ok", i),   int'(alloc_ok),        int'(tbl[i].eok));
      check($sformatf("v%0d_idx0", i), int'(alloc_idx0),      int'(tbl[i].e0));
      check($sformatf("v%0d_idx1", i), int'(alloc_idx1),      int'(tbl[i].e1));
      check($sformatf("v%0d_idx2", i), int'(alloc_idx2),      int'(tbl[i].e2));
      check($sformatf("v%0d_cnt", i),  int'(free_count),      int'(tbl[i].ecnt));
      check($sformatf("v%0d_err", i),  int'(err_double_free), int'(tbl[i].eerr));
    end

    // Asynchronous reset in the middle of an allocation burst.
    @(negedge clk);
    drive_idle();
    alloc_num = 2'd3;
    #1;
    check("pre_rst_cnt",  int'(free_count), 29);
    check("pre_rst_err",  int'(err_double_free), 1);
    check("pre_rst_idx0", int'(alloc_idx0), 35);
    @(posedge clk);
    #2;
    check("burst_cnt", int'(free_count), 26);
    #1;
    reset = 1'b1;
    #1;
    check("rst_cnt",  int'(free_count), 32);
    check("rst_err",  int'(err_double_free), 0);
    check("rst_ok",   int'(alloc_ok), 1);
    check("rst_idx0", int'(alloc_idx0), 32);
    check("rst_idx1", int'(alloc_idx1), 33);
    check("rst_idx2", int'(alloc_idx2), 34);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_idx0", int'(alloc_idx0), 32);
    @(posedge clk);
    #1;
    check("post_rst_cnt", int'(free_count), 29);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
